// File: rtl/regdump_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regdump_pkg                                                                |
// | Shared types and sizing helpers for the register-file dump reader.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package regdump_pkg;

   localparam int REG_IDX_W = 5;
   localparam int DATA_W    = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      PRESENT = 3'd2,
      GAP     = 3'd3,
      DONE    = 3'd4
   } state_t;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

   // A zero-width counter is not expressible, so the pace counter is at least 1 bit.
   function automatic int pace_cnt_w(input int pace);
      int w;
      w = clog2(pace + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regdump_pace_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regdump_pace_timer                                                         |
// | Loadable down-counter with a zero flag; holds at zero.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module regdump_pace_timer #(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_dump_reader                                                        |
// | Walks FIRST_REG..LAST_REG through a spare regfile read port and streams   |
// | each value out on valid/ready. Optional: REGDUMP_SKIP_ZERO_EN drops zero  |
// | values instead of presenting them.                                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module regfile_dump_reader
   import regdump_pkg::*;
#(
   parameter int FIRST_REG   = 0,
   parameter int LAST_REG    = 31,
   parameter int PACE_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [REG_IDX_W-1:0] rd_addr,
   input  logic [DATA_W-1:0]    rd_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic [REG_IDX_W-1:0] out_idx,
   output logic                 busy,
   output logic                 done
);

   localparam logic [REG_IDX_W-1:0] c_FIRST_IDX = REG_IDX_W'(FIRST_REG);
   localparam logic [REG_IDX_W-1:0] c_LAST_IDX  = REG_IDX_W'(LAST_REG);
   localparam int                   c_PACE_W    = pace_cnt_w(PACE_CYCLES);

   state_t               r_state,     w_state_nxt;
   logic [REG_IDX_W-1:0] r_rd_addr,   w_rd_addr_nxt;
   logic                 r_out_valid, w_out_valid_nxt;
   logic [DATA_W-1:0]    r_out_data,  w_out_data_nxt;
   logic [REG_IDX_W-1:0] r_out_idx,   w_out_idx_nxt;
   logic                 r_busy,      w_busy_nxt;
   logic                 r_done,      w_done_nxt;

   logic w_skip;
   logic w_advance;
   logic w_at_last;
   logic w_pace_load;
   logic w_pace_dec;
   logic w_pace_zero;

`ifdef REGDUMP_SKIP_ZERO_EN
   assign w_skip = (rd_data == '0);
`else
   assign w_skip = 1'b0;
`endif

   generate
      if (PACE_CYCLES > 0) begin : g_pace
         localparam logic [c_PACE_W-1:0] c_PACE_LOAD = c_PACE_W'(PACE_CYCLES - 1);
         regdump_pace_timer #(
            .CNT_W (c_PACE_W)
         ) u_pace_timer (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_pace_load),
            .i_load_val (c_PACE_LOAD),
            .i_dec      (w_pace_dec),
            .o_zero     (w_pace_zero)
         );
      end else begin : g_no_pace
         logic w_pace_unused;
         assign w_pace_unused = w_pace_load | w_pace_dec;
         assign w_pace_zero   = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rd_addr   <= c_FIRST_IDX;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rd_addr   <= w_rd_addr_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_idx   <= w_out_idx_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_rd_addr_nxt   = r_rd_addr;
      w_out_valid_nxt = r_out_valid;
      w_out_data_nxt  = r_out_data;
      w_out_idx_nxt   = r_out_idx;
      w_busy_nxt      = r_busy;
      w_done_nxt      = 1'b0;
      w_pace_load     = 1'b0;
      w_pace_dec      = 1'b0;
      w_advance       = 1'b0;
      w_at_last       = 1'b0;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_rd_addr_nxt = c_FIRST_IDX;
               w_busy_nxt    = 1'b1;
               w_state_nxt   = READ;
            end
         end
         READ: begin
            if (w_skip) begin
               w_advance = 1'b1;
               w_at_last = (r_rd_addr == c_LAST_IDX);
            end else begin
               w_out_data_nxt  = rd_data;
               w_out_idx_nxt   = r_rd_addr;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = PRESENT;
            end
         end
         PRESENT: begin
            if (out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_advance       = 1'b1;
               w_at_last       = (r_out_idx == c_LAST_IDX);
            end
         end
         GAP: begin
            if (w_pace_zero) begin
               w_state_nxt = READ;
            end else begin
               w_pace_dec = 1'b1;
            end
         end
         DONE: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Shared by a real handshake and by a skipped zero word.
      if (w_advance) begin
         if (w_at_last) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
         end else begin
            w_rd_addr_nxt = r_rd_addr + REG_IDX_W'(1);
            if (PACE_CYCLES > 0) begin
               w_state_nxt = GAP;
               w_pace_load = 1'b1;
            end else begin
               w_state_nxt = READ;
            end
         end
      end
   end

   assign rd_addr   = r_rd_addr;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_idx   = r_out_idx;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_dump_reader                                                     |
// | Self-checking bench: two readers (unpaced and paced) on one regfile model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_regfile_dump_reader;

   localparam int PACE_B = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [1:0]      start_s;
   logic [1:0]      ready_s;
   wire  [1:0]      valid_s;
   wire  [1:0]      busy_s;
   wire  [1:0]      done_s;
   wire  [1:0][4:0] addr_s;
   wire  [1:0][4:0] idx_s;
   wire  [1:0][31:0] data_s;
   wire  [1:0][31:0] rdd_s;

   logic [31:0] regs [32];
   logic [31:0] model_regs [32];
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
   } word_t;
   word_t exp_q[$];

   typedef struct {
      int k;
      int pat;
      int pct;
      int exp_words;
      int exp_done;
   } vec_t;
   vec_t vecs[4];

   always @(posedge clk) if (we) regs[wa] <= wd;
   assign rdd_s[0] = regs[addr_s[0]];
   assign rdd_s[1] = regs[addr_s[1]];

   regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .PACE_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start_s[0]), .rd_addr(addr_s[0]), .rd_data(rdd_s[0]),
      .out_valid(valid_s[0]), .out_ready(ready_s[0]), .out_data(data_s[0]),
      .out_idx(idx_s[0]), .busy(busy_s[0]), .done(done_s[0]));

   regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .PACE_CYCLES(PACE_B)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_s[1]), .rd_addr(addr_s[1]), .rd_data(rdd_s[1]),
      .out_valid(valid_s[1]), .out_ready(ready_s[1]), .out_data(data_s[1]),
      .out_idx(idx_s[1]), .busy(busy_s[1]), .done(done_s[1]));

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_ge(input string name, input int act, input int min);
      n_cmp++;
      if (act < min) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected at least %0d (cycle %0d)", name, act, min, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
   endtask

   task automatic wr(input int a, input logic [31:0] v);
      we = 1'b1;
      wa = a[4:0];
      wd = v;
      tick();
      we = 1'b0;
      model_regs[a] = v;
   endtask

   // pattern 0: r[i]=0x01010101*i; 1: random with some zeros; 2: only r5=5
   task automatic preload(input int pat);
      logic [31:0] v;
      for (int i = 0; i < 32; i++) begin
         case (pat)
            0:       v = 32'h0101_0101 * i;
            1:       v = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
            default: v = (i == 5) ? 32'h5 : 32'h0;
         endcase
         wr(i, v);
      end
   endtask

   // Reference: the words a dump must produce, in order, from the model registers.
   task automatic build_exp();
      word_t w;
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
`ifdef REGDUMP_SKIP_ZERO_EN
         if (model_regs[i] == 32'h0) continue;
`endif
         w.idx  = i[4:0];
         w.data = model_regs[i];
         exp_q.push_back(w);
      end
   endtask

   task automatic run_dump(input int k, input int pct, output int words, output int done_cyc);
      int          pace, low, hs, last_hs;
      bit          pend, got_done;
      logic [31:0] pd;
      logic [4:0]  pi;
      pace = (k == 1) ? PACE_B : 0;
      build_exp();
      low = 0; hs = 0; last_hs = -1; pend = 0; got_done = 0; done_cyc = -1;
      pd = '0; pi = '0;
      start_s[k] = 1'b1;
      tick();
      start_s[k] = 1'b0;
      for (int c = 0; c < 3000 && !got_done; c++) begin
         ready_s[k] = ($urandom_range(99) < pct);
         chk("busy_during_dump", 32'(busy_s[k]), 32'h1);
         if (valid_s[k]) begin
            if (pend) begin
               chk("hold_data", data_s[k], pd);
               chk("hold_idx", 32'(idx_s[k]), 32'(pi));
            end else begin
`ifndef REGDUMP_SKIP_ZERO_EN
               chk("valid_low_cycles", low, (hs == 0) ? 1 : pace + 1);
`else
               chk_ge("valid_low_cycles", low, (hs == 0) ? 1 : pace + 1);
`endif
               if (exp_q.size() == 0) fail("extra_word");
               else begin
                  chk("word_idx", 32'(idx_s[k]), 32'(exp_q[0].idx));
                  chk("word_data", data_s[k], exp_q[0].data);
               end
            end
            pd = data_s[k];
            pi = idx_s[k];
            low = 0;
            if (ready_s[k]) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               hs++;
               last_hs = c;
               pend = 0;
            end else begin
               pend = 1;
            end
         end else begin
            if (pend) fail("valid_dropped_without_handshake");
            pend = 0;
            low++;
         end
         if (done_s[k]) begin
            got_done = 1;
            done_cyc = c + 1;
            chk("words_left_at_done", exp_q.size(), 32'h0);
`ifndef REGDUMP_SKIP_ZERO_EN
            chk("done_after_last_hs", c, last_hs + 1);
`endif
         end
         tick();
      end
      ready_s[k] = 1'b0;
      if (!got_done) fail("dump_timeout");
      chk("busy_after_done", 32'(busy_s[k]), 32'h0);
      chk("done_single_cycle", 32'(done_s[k]), 32'h0);
      chk("valid_after_done", 32'(valid_s[k]), 32'h0);
      words = hs;
   endtask

   task automatic wait_word(input int k, input logic [4:0] idx);
      bit ok;
      ok = 0;
      for (int c = 0; c < 300; c++) begin
         if (valid_s[k] && idx_s[k] == idx) begin
            ok = 1;
            break;
         end
         ready_s[k] = 1'b1;
         tick();
      end
      if (!ok) fail("wait_word_timeout");
   endtask

   task automatic finish_dump(input int k);
      bit ok;
      ok = 0;
      ready_s[k] = 1'b1;
      for (int c = 0; c < 300 && !ok; c++) begin
         if (done_s[k]) ok = 1;
         tick();
      end
      ready_s[k] = 1'b0;
      if (!ok) fail("finish_timeout");
   endtask

   initial begin
      int words, dcyc, n_exp;
      bit got_done;

      rst = 1'b1; start_s = '0; ready_s = '0; we = 1'b0; wa = '0; wd = '0;
      tick();
      tick();
      for (int k = 0; k < 2; k++) begin
         chk("reset_valid", 32'(valid_s[k]), 32'h0);
         chk("reset_busy", 32'(busy_s[k]), 32'h0);
         chk("reset_done", 32'(done_s[k]), 32'h0);
         chk("reset_idx", 32'(idx_s[k]), 32'h0);
         chk("reset_data", data_s[k], 32'h0);
         chk("reset_rd_addr", 32'(addr_s[k]), 32'h0);
      end
      rst = 1'b0;

      // Table: full dumps, unpaced and paced, with full and partial readiness.
      vecs[0] = '{0, 0, 100, 32, 65};
      vecs[1] = '{1, 0, 100, 32, 2 * 32 + PACE_B * 31 + 1};
      vecs[2] = '{0, 0, 40, 32, -1};
      vecs[3] = '{1, 1, 60, 32, -1};
      for (int v = 0; v < 4; v++) begin
         preload(vecs[v].pat);
         run_dump(vecs[v].k, vecs[v].pct, words, dcyc);
`ifndef REGDUMP_SKIP_ZERO_EN
         chk("vec_word_count", words, vecs[v].exp_words);
         if (vecs[v].exp_done >= 0) chk("vec_done_cycle", dcyc, vecs[v].exp_done);
`endif
      end

      // Backpressure on idx 3.
      preload(0);
      start_s[0] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      wait_word(0, 5'd3);
      for (int i = 0; i < 5; i++) begin
         ready_s[0] = 1'b0;
         chk("bp_valid", 32'(valid_s[0]), 32'h1);
         chk("bp_data", data_s[0], 32'h0303_0303);
         chk("bp_idx", 32'(idx_s[0]), 32'd3);
         chk("bp_rd_addr", 32'(addr_s[0]), 32'd3);
         tick();
      end
      ready_s[0] = 1'b1;
      chk("bp_still_idx3", 32'(idx_s[0]), 32'd3);
      tick();
      chk("bp_read_cycle_valid", 32'(valid_s[0]), 32'h0);
      tick();
      chk("bp_next_valid", 32'(valid_s[0]), 32'h1);
      chk("bp_next_idx", 32'(idx_s[0]), 32'd4);
      chk("bp_next_data", data_s[0], 32'h0404_0404);
      finish_dump(0);

      // Reset in the middle of a dump, then restart from the first register.
      start_s[0] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      wait_word(0, 5'd10);
      ready_s[0] = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_valid", 32'(valid_s[0]), 32'h0);
      chk("midrst_busy", 32'(busy_s[0]), 32'h0);
      chk("midrst_idx", 32'(idx_s[0]), 32'h0);
      chk("midrst_rd_addr", 32'(addr_s[0]), 32'h0);
      tick();
      chk("midrst_idle_valid", 32'(valid_s[0]), 32'h0);
      run_dump(0, 100, words, dcyc);

      // Start held high throughout, including DONE; live write to r20 at idx 5.
      model_regs[20] = 32'hDEAD_BEEF;
      build_exp();
      n_exp = exp_q.size();
      model_regs[20] = 32'h1414_1414;
      words = 0;
      got_done = 0;
      start_s[0] = 1'b1;
      tick();
      for (int c = 0; c < 300 && !got_done; c++) begin
         ready_s[0] = 1'b1;
         we = 1'b0;
         if (valid_s[0]) begin
            if (exp_q.size() == 0) fail("live_extra_word");
            else begin
               chk("live_idx", 32'(idx_s[0]), 32'(exp_q[0].idx));
               chk("live_data", data_s[0], exp_q[0].data);
               void'(exp_q.pop_front());
            end
            words++;
            if (idx_s[0] == 5'd5) begin
               we = 1'b1; wa = 5'd20; wd = 32'hDEAD_BEEF;
               model_regs[20] = 32'hDEAD_BEEF;
            end
         end
         if (done_s[0]) got_done = 1;
         tick();
      end
      we = 1'b0;
      start_s[0] = 1'b0;
      ready_s[0] = 1'b0;
      if (!got_done) fail("live_timeout");
      chk("live_word_count", words, n_exp);
      for (int i = 0; i < 4; i++) begin
         chk("ignored_start_valid", 32'(valid_s[0]), 32'h0);
         chk("ignored_start_busy", 32'(busy_s[0]), 32'h0);
         tick();
      end

      // Write to the register being read on the same edge: old value is captured.
      start_s[0] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      wait_word(0, 5'd7);
      ready_s[0] = 1'b1;
      tick();
      chk("same_edge_rd_addr", 32'(addr_s[0]), 32'd8);
      chk("same_edge_read_valid", 32'(valid_s[0]), 32'h0);
      we = 1'b1; wa = 5'd8; wd = 32'hCAFE_0008;
      tick();
      we = 1'b0;
      model_regs[8] = 32'hCAFE_0008;
      chk("same_edge_idx", 32'(idx_s[0]), 32'd8);
      chk("same_edge_data", data_s[0], 32'h0808_0808);
      finish_dump(0);

`ifdef REGDUMP_SKIP_ZERO_EN
      preload(2);
      run_dump(0, 100, words, dcyc);
      chk("skip_zero_words_unpaced", words, 1);
      run_dump(1, 100, words, dcyc);
      chk("skip_zero_words_paced", words, 1);
`endif

      // Randomized dumps against the reference word list.
      for (int r = 0; r < 6; r++) begin
         int k;
         k = int'($urandom_range(1));
         preload(1);
         run_dump(k, int'($urandom_range(100, 20)), words, dcyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
